lab2_calc_seq: RTL

Sequencer that turns a UART character stream of the form `<hex><op><hex>` (e.g. "3+4", "a-5") into one transaction on the Lab2 4-bit ASCII hex adder/subtractor datapath.
- Validates each character and drives operands, subtract select and the launch strobe.
- Waits for the datapath's delayed ready pulse, captures the ASCII result and returns it on a valid/ready TX stream.
- Sits between the UART RX/TX front end and the adder datapath; exactly one transaction is in flight at a time.

---
 rtl/lab2_calc_pkg.sv | 29 ++
 rtl/lab2_tx_hold.sv | 32 +++
 rtl/lab2_calc_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lab2_calc_pkg.sv
// Shared types, character constants and classifiers for the calculator sequencer.
`timescale 1ns/1ps
package lab2_calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_OP = 3'd2,
    S_GET_B  = 3'd3,
    S_LAUNCH = 3'd4,
    S_WAIT   = 3'd5,
    S_ERR    = 3'd6,
    S_SEND   = 3'd7
  } state_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Digits and lowercase a-f only; the datapath does not decode uppercase.
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS);
  endfunction

endpackage

// File: rtl/lab2_tx_hold.sv
// TX output register: holds a character with valid high until the sink takes it.
`timescale 1ns/1ps
module lab2_tx_hold (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       tx_rdy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_vld_o
);

  logic [7:0] data_q;
  logic       vld_q;

  // Load wins over a transfer; data stays frozen while valid is pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= 8'h00;
      vld_q  <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      vld_q  <= 1'b1;
    end else if (vld_q && tx_rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign tx_data_o = data_q;
  assign tx_vld_o  = vld_q;

endmodule

// File: rtl/lab2_calc_seq.sv
// Sequencer: parses "<hex><op><hex>" from RX, launches one adder transaction,
// returns the adder's ASCII result (or an error character) on TX.
//
// state    | meaning
// S_IDLE   | one cycle after reset before accepting input
// S_GET_A  | waiting for operand A (hex)
// S_GET_OP | waiting for '+' or '-'
// S_GET_B  | waiting for operand B (hex)
// S_LAUNCH | launch pulse to datapath, timeout counter cleared
// S_WAIT   | waiting for datapath ready pulse or timeout
// S_ERR    | queue error character
// S_SEND   | holding TX character until sink accepts
`timescale 1ns/1ps
module lab2_calc_seq
  import lab2_calc_pkg::*;
#(
  parameter int unsigned RDY_TIMEOUT = 15,
  parameter logic [7:0]  ERR_CHAR    = 8'h3F
) (
  input  logic       i_clk_in,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_vld,
  output logic       o_rx_rdy,
  output logic [7:0] o_r1,
  output logic [7:0] o_r2,
  output logic       o_substract_signal,
  output logic       o_data_rdy,
  input  logic [7:0] i_adder_data,
  input  logic       i_adder_rdy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_vld,
  input  logic       i_tx_rdy,
  output logic       o_busy,
  output logic       o_err
);

  localparam int unsigned      CNT_W    = $clog2(RDY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RDY_TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       r1_q, r2_q;
  logic             sub_q, data_rdy_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_load_d;
  logic [7:0]       tx_char_d;

  // Decodes of the state register only.
  assign o_rx_rdy = (state_q == S_GET_A) || (state_q == S_GET_OP) || (state_q == S_GET_B);
  assign o_busy   = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_SEND);

  // Select what gets loaded into the TX holding register this cycle.
  always_comb begin
    tx_load_d = 1'b0;
    tx_char_d = ERR_CHAR;
    if ((state_q == S_WAIT) && i_adder_rdy) begin
      tx_load_d = 1'b1;
      tx_char_d = i_adder_data;
    end else if (state_q == S_ERR) begin
      tx_load_d = 1'b1;
    end
  end

  // Main sequencing FSM with registered operand/strobe outputs.
  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      r1_q       <= 8'h00;
      r2_q       <= 8'h00;
      sub_q      <= 1'b0;
      data_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: state_q <= S_GET_A;
        S_GET_A: begin
          if (i_rx_vld && (i_rx_data != CH_SPACE)) begin
            if (is_hex(i_rx_data)) begin
              r1_q    <= i_rx_data;
              state_q <= S_GET_OP;
            end else begin
              state_q <= S_ERR;
            end
          end
        end
        S_GET_OP: begin
          if (i_rx_vld && (i_rx_data != CH_SPACE)) begin
            if (is_op(i_rx_data)) begin
              sub_q   <= (i_rx_data == CH_MINUS);
              state_q <= S_GET_B;
            end else begin
              state_q <= S_ERR;
            end
          end
        end
        S_GET_B: begin
          if (i_rx_vld && (i_rx_data != CH_SPACE)) begin
            if (is_hex(i_rx_data)) begin
              r2_q       <= i_rx_data;
              data_rdy_q <= 1'b1;
              state_q    <= S_LAUNCH;
            end else begin
              state_q <= S_ERR;
            end
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A ready pulse on the final cycle still beats the timeout.
          if (i_adder_rdy) begin
            state_q <= S_SEND;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          err_q   <= 1'b1;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (o_tx_vld && i_tx_rdy) begin
            state_q <= S_GET_A;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_r1               = r1_q;
  assign o_r2               = r2_q;
  assign o_substract_signal = sub_q;
  assign o_data_rdy         = data_rdy_q;
  assign o_err              = err_q;

  lab2_tx_hold u_tx_hold (
    .clk_i     (i_clk_in),
    .rst_ni    (i_rst_n),
    .load_i    (tx_load_d),
    .data_i    (tx_char_d),
    .tx_rdy_i  (i_tx_rdy),
    .tx_data_o (o_tx_data),
    .tx_vld_o  (o_tx_vld)
  );

endmodule
